// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - N-client cacheline arbiter onto a single burst pmem port
// Round-robin or fixed-priority selection, live client passthrough, per-client grant counters.
module pmem_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int LINE_W    = 256,
  parameter int RR_MODE   = 1,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        cl_read,
  input  logic [NUM_PORTS-1:0]        cl_write,
  input  logic [NUM_PORTS*ADDR_W-1:0] cl_address,
  input  logic [NUM_PORTS*LINE_W-1:0] cl_wdata,
  output logic [LINE_W-1:0]           cl_rdata,
  output logic [NUM_PORTS-1:0]        cl_resp,
  output logic                        pmem_read,
  output logic                        pmem_write,
  output logic [ADDR_W-1:0]           pmem_address,
  output logic [LINE_W-1:0]           pmem_wdata,
  input  logic [LINE_W-1:0]           pmem_rdata,
  input  logic                        pmem_resp,
  output logic [NUM_PORTS*CNT_W-1:0]  grant_cnt
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [IDX_W-1:0]     gnt;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     win;
  logic [NUM_PORTS-1:0] req;
  logic                 any_req;
  logic                 busy_resp;

  logic [ADDR_W-1:0] addr_arr  [NUM_PORTS];
  logic [LINE_W-1:0] wdata_arr [NUM_PORTS];

  assign req       = cl_read | cl_write;
  assign any_req   = |req;
  assign busy_resp = (state == BUSY) && pmem_resp;

  // Search starts at rr_ptr in round-robin mode, at index 0 in fixed-priority mode.
  always_comb begin : pick
    logic             found;
    logic [IDX_W-1:0] idx;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (RR_MODE != 0) begin
        idx = IDX_W'((int'(rr_ptr) + k) % NUM_PORTS);
      end else begin
        idx = IDX_W'(k);
      end
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      gnt    <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        gnt <= win;
        if (RR_MODE != 0) begin
          rr_ptr <= (win == LAST_IDX) ? '0 : win + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = BUSY;
      BUSY:    if (pmem_resp) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Requests depend only on registered state/gnt and the held client inputs.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    cl_resp      = '0;
    if (state == BUSY) begin
      pmem_read    = cl_read[gnt] & ~cl_write[gnt];
      pmem_write   = cl_write[gnt];
      cl_resp[gnt] = pmem_resp;
    end
  end

  assign pmem_address = addr_arr[gnt];
  assign pmem_wdata   = wdata_arr[gnt];
  assign cl_rdata     = pmem_rdata;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    logic [CNT_W-1:0] cnt;

    assign addr_arr[i]  = cl_address[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = cl_wdata[i*LINE_W +: LINE_W];
    assign grant_cnt[i*CNT_W +: CNT_W] = cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
      end else if (busy_resp && gnt == IDX_W'(i)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb/tb_pmem_arbiter.sv - directed self-checking bench for pmem_arbiter
// Instance a: 4 ports round-robin; instance b: 4 ports fixed priority with 2-bit counters.
module tb_pmem_arbiter;

  logic clk;
  logic rst;

  logic [3:0]   a_read, a_write, a_resp;
  logic [127:0] a_addr;
  logic [255:0] a_wdata;
  logic [63:0]  a_rdata, a_pwdata, a_prdata;
  logic         a_pread, a_pwrite, a_presp;
  logic [31:0]  a_paddr;
  logic [63:0]  a_cnt;

  logic [3:0]   b_read, b_write, b_resp;
  logic [127:0] b_addr;
  logic [255:0] b_wdata;
  logic [63:0]  b_rdata, b_pwdata, b_prdata;
  logic         b_pread, b_pwrite, b_presp;
  logic [31:0]  b_paddr;
  logic [7:0]   b_cnt;

  int n_checks;
  int n_fail;

  pmem_arbiter #(.NUM_PORTS(4), .ADDR_W(32), .LINE_W(64), .RR_MODE(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst),
    .cl_read(a_read), .cl_write(a_write), .cl_address(a_addr), .cl_wdata(a_wdata),
    .cl_rdata(a_rdata), .cl_resp(a_resp),
    .pmem_read(a_pread), .pmem_write(a_pwrite), .pmem_address(a_paddr), .pmem_wdata(a_pwdata),
    .pmem_rdata(a_prdata), .pmem_resp(a_presp), .grant_cnt(a_cnt)
  );

  pmem_arbiter #(.NUM_PORTS(4), .ADDR_W(32), .LINE_W(64), .RR_MODE(0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst),
    .cl_read(b_read), .cl_write(b_write), .cl_address(b_addr), .cl_wdata(b_wdata),
    .cl_rdata(b_rdata), .cl_resp(b_resp),
    .pmem_read(b_pread), .pmem_write(b_pwrite), .pmem_address(b_paddr), .pmem_wdata(b_pwdata),
    .pmem_rdata(b_prdata), .pmem_resp(b_presp), .grant_cnt(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic a_txn(input int lat, input logic [63:0] data, output logic [3:0] seen);
    int n;
    n = 0;
    while (!(a_pread || a_pwrite) && n < 20) begin
      step();
      n++;
    end
    n_checks++;
    if (n >= 20) begin
      $display("FAIL a_txn_timeout: no downstream request after %0d cycles, required within 20", n);
      n_fail++;
    end
    repeat (lat - 1) step();
    a_prdata = data;
    a_presp  = 1'b1;
    #1;
    seen = a_resp;
    step();
    a_presp = 1'b0;
  endtask

  task automatic b_txn(output logic [3:0] seen);
    int n;
    n = 0;
    while (!(b_pread || b_pwrite) && n < 20) begin
      step();
      n++;
    end
    n_checks++;
    if (n >= 20) begin
      $display("FAIL b_txn_timeout: no downstream request after %0d cycles, required within 20", n);
      n_fail++;
    end
    b_presp = 1'b1;
    #1;
    seen = b_resp;
    step();
    b_presp = 1'b0;
  endtask

  task automatic test_reset();
    step();
    n_checks++;
    if ({a_pread, a_pwrite, a_resp} !== 6'b0) begin
      $display("FAIL reset_outputs: got %b required 000000", {a_pread, a_pwrite, a_resp});
      n_fail++;
    end
    n_checks++;
    if (a_cnt !== 64'h0 || b_cnt !== 8'h0) begin
      $display("FAIL reset_counters: got a=%h b=%h required 0", a_cnt, b_cnt);
      n_fail++;
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_read();
    a_read = 4'b0010;
    a_addr[32 +: 32] = 32'h0000_1040;
    for (int c = 1; c <= 3; c++) begin
      step();
      n_checks++;
      if (a_pread !== 1'b1 || a_pwrite !== 1'b0) begin
        $display("FAIL single_read_req_c%0d: got read=%b write=%b required 1 0", c, a_pread, a_pwrite);
        n_fail++;
      end
    end
    n_checks++;
    if (a_paddr !== 32'h0000_1040) begin
      $display("FAIL single_read_addr: got %h required 00001040", a_paddr);
      n_fail++;
    end
    a_prdata = {2{32'hA5A5_A5A5}};
    a_presp  = 1'b1;
    #1;
    n_checks++;
    if (a_resp !== 4'b0010 || a_rdata !== {2{32'hA5A5_A5A5}}) begin
      $display("FAIL single_read_resp: got resp=%b rdata=%h required 0010 a5a5a5a5a5a5a5a5", a_resp, a_rdata);
      n_fail++;
    end
    step();
    a_presp = 1'b0;
    a_read  = 4'b0000;
    n_checks++;
    if (a_pread !== 1'b0 || a_resp !== 4'b0 || a_cnt[16 +: 16] !== 16'd1) begin
      $display("FAIL single_read_done: got read=%b resp=%b cnt1=%0d required 0 0000 1", a_pread, a_resp, a_cnt[16 +: 16]);
      n_fail++;
    end
    step();
  endtask

  task automatic test_stray_resp();
    a_presp = 1'b1;
    #1;
    n_checks++;
    if (a_resp !== 4'b0) begin
      $display("FAIL stray_resp_idle: got resp=%b required 0000", a_resp);
      n_fail++;
    end
    step();
    a_presp = 1'b0;
    n_checks++;
    if (a_cnt !== 64'h0000_0000_0001_0000 || a_pread !== 1'b0) begin
      $display("FAIL stray_resp_cnt: got cnt=%h read=%b required 0000000000010000 0", a_cnt, a_pread);
      n_fail++;
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] seen;
    logic [3:0] exp;
    do_reset();
    a_read = 4'hF;
    for (int t = 0; t < 5; t++) begin
      a_txn(2, 64'h0, seen);
      exp = 4'b0001 << (t % 4);
      n_checks++;
      if (seen !== exp) begin
        $display("FAIL rr_grant_%0d: got resp=%b required %b", t, seen, exp);
        n_fail++;
      end
      if (t == 3) begin
        n_checks++;
        if (a_cnt !== {4{16'd1}}) begin
          $display("FAIL rr_counts: got %h required 0001000100010001", a_cnt);
          n_fail++;
        end
      end
    end
    a_read = 4'h0;
    step();
  endtask

  task automatic test_read_write();
    a_read  = 4'b0001;
    a_write = 4'b0001;
    a_addr[31:0]  = 32'h0000_2000;
    a_wdata[63:0] = 64'h1234_5678_9ABC_DEF0;
    step();
    n_checks++;
    if (a_pwrite !== 1'b1 || a_pread !== 1'b0) begin
      $display("FAIL rw_dir: got write=%b read=%b required 1 0", a_pwrite, a_pread);
      n_fail++;
    end
    n_checks++;
    if (a_pwdata !== 64'h1234_5678_9ABC_DEF0 || a_paddr !== 32'h0000_2000) begin
      $display("FAIL rw_data: got wdata=%h addr=%h required 123456789abcdef0 00002000", a_pwdata, a_paddr);
      n_fail++;
    end
    a_presp = 1'b1;
    #1;
    n_checks++;
    if (a_resp !== 4'b0001) begin
      $display("FAIL rw_resp: got %b required 0001", a_resp);
      n_fail++;
    end
    step();
    a_presp = 1'b0;
    a_read  = 4'b0;
    a_write = 4'b0;
    step();
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    a_read = 4'b0100;
    step();
    step();
    n_checks++;
    if (a_pread !== 1'b1) begin
      $display("FAIL rst_busy_pre: got read=%b required 1", a_pread);
      n_fail++;
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (a_pread !== 1'b0 || a_resp !== 4'b0) begin
      $display("FAIL rst_busy_async: got read=%b resp=%b required 0 0000", a_pread, a_resp);
      n_fail++;
    end
    a_read = 4'b0;
    step();
    rst = 1'b0;
    a_presp = 1'b1;
    #1;
    n_checks++;
    if (a_resp !== 4'b0) begin
      $display("FAIL rst_late_resp: got resp=%b required 0000", a_resp);
      n_fail++;
    end
    step();
    a_presp = 1'b0;
    n_checks++;
    if (a_cnt !== 64'h0 || a_pread !== 1'b0) begin
      $display("FAIL rst_late_cnt: got cnt=%h read=%b required 0 0", a_cnt, a_pread);
      n_fail++;
    end
  endtask

  task automatic test_fixed_priority();
    logic [3:0] seen;
    do_reset();
    b_read = 4'b0101;
    b_txn(seen);
    n_checks++;
    if (seen !== 4'b0001) begin
      $display("FAIL fp_first: got %b required 0001", seen);
      n_fail++;
    end
    b_read[0] = 1'b0;
    step();
    b_read[0] = 1'b1;
    b_txn(seen);
    n_checks++;
    if (seen !== 4'b0001) begin
      $display("FAIL fp_rerequest: got %b required 0001", seen);
      n_fail++;
    end
    b_read[0] = 1'b0;
    step();
    b_txn(seen);
    n_checks++;
    if (seen !== 4'b0100) begin
      $display("FAIL fp_port2: got %b required 0100", seen);
      n_fail++;
    end
    b_read = 4'b0;
    step();
    n_checks++;
    if (b_cnt !== 8'h12) begin
      $display("FAIL fp_counts: got %h required 12", b_cnt);
      n_fail++;
    end
  endtask

  task automatic test_counter_wrap();
    logic [3:0] seen;
    do_reset();
    for (int t = 0; t < 5; t++) begin
      b_read = 4'b0001;
      b_txn(seen);
      b_read = 4'b0;
      step();
    end
    n_checks++;
    if (b_cnt !== 8'h01) begin
      $display("FAIL cnt_wrap: got %h required 01", b_cnt);
      n_fail++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    a_read = '0; a_write = '0; a_addr = '0; a_wdata = '0; a_prdata = '0; a_presp = 1'b0;
    b_read = '0; b_write = '0; b_addr = '0; b_wdata = '0; b_prdata = '0; b_presp = 1'b0;
    test_reset();
    test_single_read();
    test_stray_resp();
    test_round_robin();
    test_read_write();
    test_reset_mid_busy();
    test_fixed_priority();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
